// File: rtl/fence_drain_controller_pkg.sv
// Shared types and defaults for the fence drain controller.
// FSM encoding and outstanding-counter sizing.
package fence_drain_controller_pkg;

   typedef enum logic [1:0] {
      FS_IDLE    = 2'b00,
      FS_DRAIN   = 2'b01,
      FS_FLUSH   = 2'b10,
      FS_RELEASE = 2'b11
   } fence_state_t;

   localparam int DEF_CNT_W           = 3;
   localparam int DEF_MAX_OUTSTANDING = 4;
   localparam int DEF_DRAIN_TIMEOUT   = 64;

endpackage

// File: rtl/fence_drain_controller_mem_outstanding_counter.sv
// Saturating up/down count of in-flight data-memory transactions.
// Over/underflow attempts hold the count and set a sticky error.
module mem_outstanding_counter
   import fence_drain_controller_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic rst_n,
   input  logic up,
   input  logic down,
   output logic zero,
   output logic err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   // next count: req and rsp together cancel out
   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      unique case ({up, down})
         2'b10: begin
            if (count_q == CNT_MAX) err_d = 1'b1;
            else count_d = count_q + 1'b1;
         end
         2'b01: begin
            if (count_q == '0) err_d = 1'b1;
            else count_d = count_q - 1'b1;
         end
         default: ;
      endcase
   end

   // count and sticky error registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign zero = (count_q == '0);
   assign err  = err_q;

endmodule

// File: rtl/fence_drain_controller.sv
// FENCE / FENCE.I sequencer: stall ID, drain the back end,
// optionally flush the I-cache, then release for one cycle.
module fence_drain_controller
   import fence_drain_controller_pkg::*;
#(
   parameter int CNT_W           = DEF_CNT_W,
   parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int DRAIN_TIMEOUT   = DEF_DRAIN_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic id_fence_valid,
   input  logic id_fence_i,
   input  logic ex_valid,
   input  logic mem_valid,
   input  logic wb_valid,
   input  logic dmem_req_fire,
   input  logic dmem_rsp_fire,
   input  logic icache_flush_ack,
   output logic is_fence,
   output logic icache_flush_req,
   output logic fence_done,
   output logic fence_i_refetch,
   output logic drain_timeout,
   output logic mem_count_err
);

   localparam logic [1:0] S_IDLE    = FS_IDLE;
   localparam logic [1:0] S_DRAIN   = FS_DRAIN;
   localparam logic [1:0] S_FLUSH   = FS_FLUSH;
   localparam logic [1:0] S_RELEASE = FS_RELEASE;

   localparam int TMO_W =
      (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);

   logic [1:0]       state_q, state_d;
   logic             fence_i_q, fence_i_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_err_q, tmo_err_d;
   logic             cnt_zero;
   logic             drained;
   logic             tmo_hit;

   mem_outstanding_counter #(
      .CNT_W           (CNT_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .up    (dmem_req_fire),
      .down  (dmem_rsp_fire),
      .zero  (cnt_zero),
      .err   (mem_count_err)
   );

   // back end empty and no memory traffic in flight or in motion
   always_comb begin
      drained = !ex_valid && !mem_valid && !wb_valid &&
                cnt_zero && !dmem_req_fire && !dmem_rsp_fire;
      tmo_hit = (DRAIN_TIMEOUT > 0) && (tmo_q == TMO_LAST);
   end

   // fence sequencing and drain watchdog
   always_comb begin
      state_d   = state_q;
      fence_i_d = fence_i_q;
      tmo_d     = tmo_q;
      tmo_err_d = tmo_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (id_fence_valid) begin
               fence_i_d = id_fence_i;
               tmo_d     = '0;
               state_d   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_hit) tmo_err_d = 1'b1;
            if (drained || tmo_hit)
               state_d = fence_i_q ? S_FLUSH : S_RELEASE;
         end
         S_FLUSH: begin
            if (icache_flush_ack) state_d = S_RELEASE;
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, fence kind, watchdog registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         fence_i_q <= 1'b0;
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fence_i_q <= fence_i_d;
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   // stall is combinational in IDLE so it bites on the decode cycle
   always_comb begin
      is_fence         = 1'b0;
      icache_flush_req = 1'b0;
      fence_done       = 1'b0;
      fence_i_refetch  = 1'b0;
      unique case (state_q)
         S_IDLE:    is_fence = id_fence_valid;
         S_DRAIN:   is_fence = 1'b1;
         S_FLUSH: begin
            is_fence         = 1'b1;
            icache_flush_req = 1'b1;
         end
         S_RELEASE: begin
            fence_done      = 1'b1;
            fence_i_refetch = fence_i_q;
         end
      endcase
   end

   assign drain_timeout = tmo_err_q;

endmodule

// File: doc/fence_drain_controller.md
# fence_drain_controller

- Sequences FENCE and FENCE.I in the RV32I pipeline.
- On a fence in ID it raises `is_fence` to the hazard detection unit, which freezes PC/IF-ID and inserts bubbles. It holds that stall until EX/MEM/WB are empty and no data-memory transactions are outstanding.
- For FENCE.I it also performs an instruction-cache flush handshake.
- When done, it drops the stall for one cycle so the fence leaves ID, and pulses completion/refetch strobes.

## Interface

Parameters:
- `CNT_W`, 3: width of the outstanding data-memory counter.
- `MAX_OUTSTANDING`, 4: counter ceiling; must be ≤ 2^CNT_W − 1.
- `DRAIN_TIMEOUT`, 64: maximum number of DRAIN cycles. 0 disables the timeout.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `rst_n`  in  1  reset, synchronous, active-low.
- `id_fence_valid`  in  1  valid FENCE or FENCE.I currently in ID.
- `id_fence_i`  in  1  qualifies `id_fence_valid`: 1 = FENCE.I.
- `ex_valid`, `mem_valid`, `wb_valid`  in  1 each  a non-bubble instruction is in that stage.
- `dmem_req_fire`  in  1  data-memory request accepted this cycle.
- `dmem_rsp_fire`  in  1  data-memory response returned this cycle.
- `icache_flush_ack`  in  1  I-cache flush complete.
- `is_fence`  out  1  stall request to the hazard detection unit.
- `icache_flush_req`  out  1  level request, held until acknowledged.
- `fence_done`  out  1  one-cycle pulse, issued in RELEASE.
- `fence_i_refetch`  out  1  one-cycle pulse in RELEASE, FENCE.I only; IF refetches from PC+4.
- `drain_timeout`  out  1  sticky error flag.
- `mem_count_err`  out  1  sticky error flag.

## Operation

States: IDLE, DRAIN, FLUSH, RELEASE.

IDLE
- `is_fence = id_fence_valid`. This is combinational, so the stall takes effect in the same cycle the fence is decoded.
- If `id_fence_valid`: latch `id_fence_i` into `fence_i_q`, clear the timeout counter, go to DRAIN.

DRAIN
- `is_fence = 1`.
- Drain condition: `ex_valid`, `mem_valid` and `wb_valid` are all 0, registered count = 0, and neither fire input is high this cycle.
- When the drain condition holds: go to FLUSH if `fence_i_q`, else to RELEASE.
- Timeout counter increments each DRAIN cycle. When it reaches `DRAIN_TIMEOUT` (if nonzero): set `drain_timeout` and take the same exit as above.

FLUSH
- `is_fence = 1`, `icache_flush_req = 1`.
- On `icache_flush_ack`: go to RELEASE.
- `icache_flush_req` drops in the cycle after the ack.

RELEASE
- `is_fence = 0`, `fence_done = 1`, `fence_i_refetch = fence_i_q`.
- `id_fence_valid` is ignored, because the same fence is still in ID this cycle.
- Always go to IDLE.

Outstanding counter
- +1 on `dmem_req_fire` alone; −1 on `dmem_rsp_fire` alone; unchanged when both or neither are high.
- Response at count 0: hold 0, set `mem_count_err`.
- Request at `MAX_OUTSTANDING`: hold, set `mem_count_err`.
- The counter runs in every state, not only during a fence.

## Timing

- Reset (`rst_n` = 0 at a rising edge) → next cycle:
  - State = IDLE; count, `fence_i_q`, timeout counter and both sticky flags = 0.
  - `icache_flush_req`, `fence_done` and `fence_i_refetch` = 0.
  - `is_fence` follows the IDLE rule.
- Reset mid-fence aborts the fence with no pulses.
- Minimum fence latency, with an empty pipeline and count 0:
  - `is_fence` high for 2 cycles (IDLE, DRAIN), then RELEASE, then IDLE.
- Typical latency after a stall begins: the bubble inserted in the stall cycle reaches WB 3 cycles later.
- All outputs except `is_fence` are registered-state decodes, with no combinational path from the inputs.
- `icache_flush_ack` is only sampled in FLUSH; an ack arriving in any other state is ignored.
- Back-to-back fences: the next fence is accepted in the IDLE cycle after RELEASE.

## Structure

- Shared pipeline package:
  - `fence_state_t` with 2-bit encoding IDLE=00, DRAIN=01, FLUSH=10, RELEASE=11.
  - Default values for `CNT_W` and `MAX_OUTSTANDING`.
- One sub-module: `mem_outstanding_counter`. It has up/down inputs, a saturating count, a sticky error flag and a `zero` output.
- FSM, timeout counter and output decode live in the top module.

## Test plan

- Empty-pipeline FENCE: cycle 0 `id_fence_valid=1`, `id_fence_i=0`, all stage valids 0, count 0.
  - Required: `is_fence`=1 in cycles 0–1; cycle 2 `is_fence`=0 and `fence_done`=1; cycle 3 IDLE.
  - `fence_i_refetch` never asserts.
- Two outstanding loads: count=2 at fence entry; `dmem_rsp_fire` at cycles 3 and 5.
  - Required: count reaches 0 in cycle 6, RELEASE in cycle 7; `is_fence`=1 in cycles 0–6.
- FENCE.I: drain satisfied at cycle 1; `icache_flush_ack` at cycle 5.
  - Required: `icache_flush_req`=1 in cycles 2–5.
  - RELEASE in cycle 6 with `fence_done`=1 and `fence_i_refetch`=1.
- Simultaneous fire: count=1 in DRAIN, `dmem_req_fire` and `dmem_rsp_fire` both high for one cycle.
  - Required: count stays 1 and the FSM stays in DRAIN.
  - Then a `dmem_rsp_fire` at count 0 sets `mem_count_err`=1 and count stays 0.
- Timeout: `DRAIN_TIMEOUT=8`, `mem_valid` stuck at 1.
  - Required: after 8 DRAIN cycles, `drain_timeout`=1 (sticky) and the next state is RELEASE.
- Reset in FLUSH: `rst_n`=0 for one cycle.
  - Required: next cycle IDLE, `icache_flush_req`=0, count 0, no `fence_done` pulse.
